flash_op_sequencer: RTL
=======================

Name: flash_op_sequencer

Overview:
- Sequences complete SPI NOR flash operations (read, page program, sector erase, status read) over a byte-level SPI engine.
- Turns one latched request into the opcode/address/data byte stream, including the write-enable preamble and write-in-progress polling.
- Sits between the bootstrap control logic (requester) and the SPI shifter that owns f_sclk/f_cs/f_mosi/f_miso.

Parameters:
POLL_LIMIT, 65535, maximum RDSR polls before an operation is aborted with err.
POLL_W, 16, width of the poll counter; POLL_LIMIT must fit in POLL_W bits.

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
req_valid  in  1  request offered
req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
req_op  in  2  0=READ(03h), 1=PROGRAM(02h), 2=SECTOR_ERASE(20h), 3=READ_STATUS(05h)
req_addr  in  24  flash byte address
req_len  in  8  data byte count; 0 encodes 256; ignored for ERASE and READ_STATUS
wr_data  in  8  program data byte
wr_data_valid  in  1  program byte offered
wr_data_ready  out  1  high while waiting for a program byte
rd_data  out  8  read or status byte
rd_valid  out  1  one-cycle strobe qualifying rd_data
busy  out  1  high when not in IDLE
done  out  1  one-cycle pulse at end of operation
err  out  1  poll timeout; valid only with done
spi_start  out  1  one-cycle pulse launching one byte transfer
spi_tx  out  8  byte to shift out; valid with spi_start
spi_last  out  1  engine raises CS after this byte; valid with spi_start
spi_done  in  1  one-cycle pulse when the launched byte completes
spi_rx  in  8  byte shifted in; valid with spi_done

Behaviour:
- Reset values: req_ready=0 during reset, then 1 in IDLE. All other outputs 0, including spi_tx and rd_data.
- Reset mid-operation: return to IDLE immediately. No done pulse; any engine CS state is cleared by the engine's own reset.
- Accept: latch op/addr/len, leave IDLE, pulse spi_start for the first byte on the next cycle.
- Byte rule:
  - At most one byte outstanding.
  - The next spi_start is issued no earlier than the cycle after spi_done.
  - spi_start never coincides with spi_done.
  - spi_done while no byte is outstanding is ignored.
- States: IDLE, WREN, CMD, ADDR, DATA, POLL_CMD, POLL_RD, FINISH.
- Byte sequences per op (last = spi_last):
  - READ: 03h, addr[23:16], addr[15:8], addr[7:0], then len bytes of FFh (last=1 on the final byte). Each data spi_done copies spi_rx to rd_data with rd_valid=1 that cycle.
  - PROGRAM: 06h (last=1), then 02h, addr x3, then len data bytes (last=1 on the final one), then poll.
    - In DATA, wr_data_ready=1 while no byte is outstanding.
    - On wr_data_valid&&wr_data_ready: the byte is captured and spi_start pulses with it next cycle.
    - Stall indefinitely if wr_data_valid stays low.
  - SECTOR_ERASE: 06h (last=1), 20h, addr x3 (last=1 on addr[7:0]), then poll.
  - READ_STATUS: 05h, FFh (last=1); rd_data=spi_rx with rd_valid on the second spi_done, then FINISH.
- Poll:
  - Send 05h (last=0), then FFh (last=1), and increment the poll counter.
  - If spi_rx[0]=0: go to FINISH with err=0.
  - Else if the poll counter == POLL_LIMIT: go to FINISH with err=1.
  - Else repeat.
  - The poll counter clears on request accept.
- FINISH: done=1 for one cycle (err alongside), then IDLE. req_ready rises the cycle after done, so back-to-back requests are spaced by at least one cycle.
- Length counter: 9-bit internal, loaded with (req_len==0 ? 256 : req_len), decremented per data byte launched. last=1 when the launched byte is the final one (counter==1).
- The sequencer does not split page boundaries; address wrap within a page is the flash's behaviour.

Test Plan:
- READ, addr=000100h, len=4; engine returns rx AA,BB,CC,DD on data bytes -> spi_tx 03,00,01,00,FF,FF,FF,FF; last only on the 8th byte; rd_valid x4 with AA..DD; one done, err=0.
- PROGRAM, addr=000000h, len=2, data 8C,25; status returns 03h twice then 00h -> tx 06(last),02,00,00,00,8C,25(last),05,FF(last) repeated 3x; done with err=0; wr_data_ready handshakes exactly 2.
- SECTOR_ERASE with POLL_LIMIT=3; status always 01h -> exactly 3 poll pairs, then done=1 with err=1, then IDLE.
- READ, len=0 -> exactly 256 FFh data bytes; last only on the final one; 256 rd_valid pulses.
- PROGRAM with wr_data_valid held low 20 cycles mid-DATA -> no spi_start during the stall; resumes on valid; byte order preserved.
- Assert n_rst during the ADDR phase of READ -> busy=0, done never pulses, req_ready=1 after reset release; a new READ_STATUS completes normally.

Source files
------------

// File: rtl/flash_op_sequencer.sv
// SPI NOR operation sequencer: expands one latched request into the WREN/opcode/address/data
// byte stream for a byte-level SPI engine, including write-in-progress status polling.
module flash_op_sequencer #(
  parameter int unsigned POLL_LIMIT = 65535,
  parameter int unsigned POLL_W     = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_data_valid,
  output logic        wr_data_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  output logic        spi_last,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx
);

  typedef enum logic [2:0] {
    StIdle, StWren, StCmd, StAddr, StData, StPollCmd, StPollRd, StFinish
  } state_e;

  localparam logic [1:0] OpRead   = 2'd0;
  localparam logic [1:0] OpProg   = 2'd1;
  localparam logic [1:0] OpErase  = 2'd2;
  localparam logic [1:0] OpStatus = 2'd3;

  localparam logic [7:0] CmdWren = 8'h06;
  localparam logic [7:0] CmdRdsr = 8'h05;
  localparam logic [7:0] Dummy   = 8'hFF;

  localparam logic [POLL_W-1:0] PollLimitW = POLL_W'(POLL_LIMIT);

  function automatic logic [7:0] opcode(input logic [1:0] op);
    logic [7:0] code;
    unique case (op)
      OpRead:  code = 8'h03;
      OpProg:  code = 8'h02;
      OpErase: code = 8'h20;
      default: code = 8'h05;
    endcase
    return code;
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [23:0]       addr_q, addr_d;
  logic [8:0]        len_q, len_d;
  logic [1:0]        addr_idx_q, addr_idx_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d, poll_cnt_inc;
  logic              err_q, err_d;
  logic              inflight_q, inflight_d;
  logic              ready_en_q;
  logic              spi_start_q, spi_start_d;
  logic [7:0]        spi_tx_q, spi_tx_d;
  logic              spi_last_q, spi_last_d;
  logic [7:0]        rd_data_q, rd_data_d;

  logic              byte_done;
  logic              launch;
  logic [7:0]        launch_tx;
  logic              launch_last;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      op_q        <= 2'd0;
      addr_q      <= 24'd0;
      len_q       <= 9'd0;
      addr_idx_q  <= 2'd0;
      poll_cnt_q  <= '0;
      err_q       <= 1'b0;
      inflight_q  <= 1'b0;
      ready_en_q  <= 1'b0;
      spi_start_q <= 1'b0;
      spi_tx_q    <= 8'd0;
      spi_last_q  <= 1'b0;
      rd_data_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      addr_idx_q  <= addr_idx_d;
      poll_cnt_q  <= poll_cnt_d;
      err_q       <= err_d;
      inflight_q  <= inflight_d;
      ready_en_q  <= 1'b1;
      spi_start_q <= spi_start_d;
      spi_tx_q    <= spi_tx_d;
      spi_last_q  <= spi_last_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    len_d        = len_q;
    addr_idx_d   = addr_idx_q;
    poll_cnt_d   = poll_cnt_q;
    err_d        = err_q;
    inflight_d   = inflight_q;
    rd_data_d    = rd_data_q;
    spi_start_d  = 1'b0;
    spi_tx_d     = spi_tx_q;
    spi_last_d   = spi_last_q;
    launch       = 1'b0;
    launch_tx    = 8'd0;
    launch_last  = 1'b0;
    poll_cnt_inc = poll_cnt_q + 1'b1;

    // A completion only counts for a byte that is actually in flight.
    byte_done     = spi_done && inflight_q && !spi_start_q;
    rd_valid      = byte_done && (state_q == StData) && ((op_q == OpRead) || (op_q == OpStatus));
    wr_data_ready = (state_q == StData) && (op_q == OpProg) && !inflight_q && (len_q != 9'd0);

    if (rd_valid) rd_data_d = spi_rx;
    if (byte_done) inflight_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          op_d       = req_op;
          addr_d     = req_addr;
          len_d      = (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
          addr_idx_d = 2'd0;
          poll_cnt_d = '0;
          err_d      = 1'b0;
          launch     = 1'b1;
          if ((req_op == OpProg) || (req_op == OpErase)) begin
            launch_tx   = CmdWren;
            launch_last = 1'b1;
            state_d     = StWren;
          end else begin
            launch_tx = opcode(req_op);
            state_d   = StCmd;
          end
        end
      end
      StWren: begin
        if (byte_done) begin
          launch    = 1'b1;
          launch_tx = opcode(op_q);
          state_d   = StCmd;
        end
      end
      StCmd: begin
        if (byte_done) begin
          launch = 1'b1;
          if (op_q == OpStatus) begin
            // Status read reuses the data phase with a single dummy byte.
            launch_tx   = Dummy;
            launch_last = 1'b1;
            len_d       = 9'd0;
            state_d     = StData;
          end else begin
            launch_tx  = addr_q[23:16];
            addr_idx_d = 2'd1;
            state_d    = StAddr;
          end
        end
      end
      StAddr: begin
        if (byte_done) begin
          if (addr_idx_q == 2'd3) begin
            if (op_q == OpErase) begin
              launch    = 1'b1;
              launch_tx = CmdRdsr;
              state_d   = StPollCmd;
            end else if (op_q == OpRead) begin
              launch      = 1'b1;
              launch_tx   = Dummy;
              launch_last = (len_q == 9'd1);
              len_d       = len_q - 9'd1;
              state_d     = StData;
            end else begin
              state_d = StData;
            end
          end else begin
            launch      = 1'b1;
            launch_tx   = (addr_idx_q == 2'd1) ? addr_q[15:8] : addr_q[7:0];
            launch_last = (op_q == OpErase) && (addr_idx_q == 2'd2);
            addr_idx_d  = addr_idx_q + 2'd1;
          end
        end
      end
      StData: begin
        if (op_q == OpProg) begin
          if (wr_data_valid && wr_data_ready) begin
            launch      = 1'b1;
            launch_tx   = wr_data;
            launch_last = (len_q == 9'd1);
            len_d       = len_q - 9'd1;
          end else if (byte_done && (len_q == 9'd0)) begin
            launch    = 1'b1;
            launch_tx = CmdRdsr;
            state_d   = StPollCmd;
          end
        end else if (byte_done) begin
          if (len_q == 9'd0) begin
            err_d   = 1'b0;
            state_d = StFinish;
          end else begin
            launch      = 1'b1;
            launch_tx   = Dummy;
            launch_last = (len_q == 9'd1);
            len_d       = len_q - 9'd1;
          end
        end
      end
      StPollCmd: begin
        if (byte_done) begin
          launch      = 1'b1;
          launch_tx   = Dummy;
          launch_last = 1'b1;
          state_d     = StPollRd;
        end
      end
      StPollRd: begin
        if (byte_done) begin
          poll_cnt_d = poll_cnt_inc;
          if (!spi_rx[0]) begin
            err_d   = 1'b0;
            state_d = StFinish;
          end else if (poll_cnt_inc == PollLimitW) begin
            err_d   = 1'b1;
            state_d = StFinish;
          end else begin
            launch    = 1'b1;
            launch_tx = CmdRdsr;
            state_d   = StPollCmd;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (launch) begin
      spi_start_d = 1'b1;
      spi_tx_d    = launch_tx;
      spi_last_d  = launch_last;
      inflight_d  = 1'b1;
    end
  end

  assign req_ready = ready_en_q && (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFinish);
  assign err       = (state_q == StFinish) && err_q;
  assign spi_start = spi_start_q;
  assign spi_tx    = spi_tx_q;
  assign spi_last  = spi_last_q;
  assign rd_data   = rd_valid ? spi_rx : rd_data_q;

endmodule
